// File: rtl/tproc_pkg.sv
// Shared widths and FSM encoding for the instruction-memory loader.
package tproc_pkg;

  localparam int unsigned DEF_INSTR_W = 64;
  localparam int unsigned DEF_ADDR_W  = 10;
  localparam int unsigned DEF_DEPTH   = 1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_LAUNCH = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

endpackage

// File: rtl/instr_wr_stage.sv
// One-cycle write register between an accepted host word and the instruction memory.
module instr_wr_stage
  import tproc_pkg::*;
#(
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_data
);

  logic               we_q,   we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] data_q, data_d;

  // Address and data hold their last values when no write is pending.
  always_comb begin
    we_d   = wr_en;
    addr_d = addr_q;
    data_d = data_q;
    if (wr_en) begin
      addr_d = wr_addr;
      data_d = wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign mem_we   = we_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;

endmodule

// File: rtl/instr_loader.sv
// Host-side loader: streams a burst of instruction words into memory from address 0,
// pulses acc_enable once the last word is written, and stays busy until acc_done.
module instr_loader
  import tproc_pkg::*;
#(
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               host_start,
  input  logic [ADDR_W:0]    host_count,
  input  logic               host_valid,
  input  logic [INSTR_W-1:0] host_data,
  output logic               host_ready,
  input  logic               abort,
  input  logic               acc_done,
  output logic               load_instr_enable,
  output logic [ADDR_W-1:0]  load_instr_addr,
  output logic [INSTR_W-1:0] instr_data,
  output logic               acc_enable,
  output logic               busy,
  output logic [ADDR_W:0]    loaded_count,
  output logic               err_count,
  output logic               err_busy
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e             state_q,   state_d;
  logic [CNT_W-1:0]   count_q,   count_d;
  logic [CNT_W-1:0]   loaded_q,  loaded_d;
  logic [ADDR_W-1:0]  idx_q,     idx_d;
  logic               err_cnt_q, err_cnt_d;
  logic               err_bsy_q, err_bsy_d;
  logic               acc_en_q,  acc_en_d;
  logic               ready_q,   ready_d;
  logic               busy_q,    busy_d;

  logic accept;
  logic last_word;
  logic count_ok;

  assign accept    = ready_q & host_valid;
  assign last_word = (CNT_W'(idx_q) == (count_q - CNT_W'(1)));
  assign count_ok  = (host_count != '0) && (host_count <= CNT_W'(DEPTH));

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    loaded_d  = loaded_q;
    idx_d     = idx_q;
    err_cnt_d = err_cnt_q;
    err_bsy_d = err_bsy_q;
    acc_en_d  = 1'b0;

    if (host_start && (state_q != ST_IDLE)) begin
      err_bsy_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (host_start) begin
          if (count_ok) begin
            count_d  = host_count;
            idx_d    = '0;
            loaded_d = '0;
            state_d  = ST_LOAD;
          end else begin
            err_cnt_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          idx_d    = idx_q + ADDR_W'(1);
          loaded_d = loaded_q + CNT_W'(1);
        end
        // Abort wins over launch: an aborted session never starts the accelerator.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (accept && last_word) begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        acc_en_d = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (acc_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_LOAD);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      loaded_q  <= '0;
      idx_q     <= '0;
      err_cnt_q <= 1'b0;
      err_bsy_q <= 1'b0;
      acc_en_q  <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      loaded_q  <= loaded_d;
      idx_q     <= idx_d;
      err_cnt_q <= err_cnt_d;
      err_bsy_q <= err_bsy_d;
      acc_en_q  <= acc_en_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  instr_wr_stage #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W)
  ) u_wr_stage (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (accept),
    .wr_addr  (idx_q),
    .wr_data  (host_data),
    .mem_we   (load_instr_enable),
    .mem_addr (load_instr_addr),
    .mem_data (instr_data)
  );

  assign host_ready   = ready_q;
  assign busy         = busy_q;
  assign acc_enable   = acc_en_q;
  assign loaded_count = loaded_q;
  assign err_count    = err_cnt_q;
  assign err_busy     = err_bsy_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: nominal burst, backpressure, illegal counts,
// abort, start-while-running and asynchronous reset mid-load.
module tb_instr_loader;

  localparam int unsigned IW = 64;
  localparam int unsigned AW = 10;
  localparam int unsigned CW = AW + 1;

  logic          clk;
  logic          rst;
  logic          host_start;
  logic [CW-1:0] host_count;
  logic          host_valid;
  logic [IW-1:0] host_data;
  logic          host_ready;
  logic          abort;
  logic          acc_done;
  logic          load_instr_enable;
  logic [AW-1:0] load_instr_addr;
  logic [IW-1:0] instr_data;
  logic          acc_enable;
  logic          busy;
  logic [CW-1:0] loaded_count;
  logic          err_count;
  logic          err_busy;

  instr_loader dut (
    .clk               (clk),
    .rst               (rst),
    .host_start        (host_start),
    .host_count        (host_count),
    .host_valid        (host_valid),
    .host_data         (host_data),
    .host_ready        (host_ready),
    .abort             (abort),
    .acc_done          (acc_done),
    .load_instr_enable (load_instr_enable),
    .load_instr_addr   (load_instr_addr),
    .instr_data        (instr_data),
    .acc_enable        (acc_enable),
    .busy              (busy),
    .loaded_count      (loaded_count),
    .err_count         (err_count),
    .err_busy          (err_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Mid-cycle log of accepts, memory writes and start pulses.
  logic [AW-1:0] wr_addr [64];
  logic [IW-1:0] wr_data [64];
  int            wr_cyc  [64];
  int            acpt_cyc[64];
  int            n_wr   = 0;
  int            n_acpt = 0;
  int            n_acc  = 0;
  int            acc_at = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (host_valid && host_ready && n_acpt < 64) begin
        acpt_cyc[n_acpt] = cyc;
        n_acpt = n_acpt + 1;
      end
      if (load_instr_enable && n_wr < 64) begin
        wr_addr[n_wr] = load_instr_addr;
        wr_data[n_wr] = instr_data;
        wr_cyc[n_wr]  = cyc;
        n_wr = n_wr + 1;
      end
      if (acc_enable) begin
        n_acc  = n_acc + 1;
        acc_at = cyc;
      end
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [CW-1:0] cnt);
    host_start = 1'b1;
    host_count = cnt;
    tick();
    host_start = 1'b0;
  endtask

  task automatic finish_run();
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
  endtask

  localparam logic [IW-1:0] W0 = 64'h0003_1000_0001_5758;
  localparam logic [IW-1:0] W1 = 64'h0003_1000_0001_5759;

  int bw, ba, bacc;
  logic [5:0] pattern;

  initial begin
    rst        = 1'b1;
    host_start = 1'b0;
    host_count = '0;
    host_valid = 1'b0;
    host_data  = '0;
    abort      = 1'b0;
    acc_done   = 1'b0;
    repeat (2) tick();

    check("rst_busy",   64'(busy), 64'd0);
    check("rst_ready",  64'(host_ready), 64'd0);
    check("rst_we",     64'(load_instr_enable), 64'd0);
    check("rst_acc",    64'(acc_enable), 64'd0);
    check("rst_addr",   64'(load_instr_addr), 64'd0);
    check("rst_data",   instr_data, 64'd0);
    check("rst_loaded", 64'(loaded_count), 64'd0);
    check("rst_errs",   64'({err_count, err_busy}), 64'd0);
    rst = 1'b0;
    tick();

    // Nominal two-word load.
    start(CW'(2));
    check("nom_ready", 64'(host_ready), 64'd1);
    bw = n_wr; ba = n_acpt; bacc = n_acc;
    host_valid = 1'b1; host_data = W0; tick();
    host_data = W1; tick();
    host_valid = 1'b0;
    check("nom_ready_off", 64'(host_ready), 64'd0);
    repeat (4) tick();
    check("nom_nwr",   64'(n_wr - bw), 64'd2);
    check("nom_addr0", 64'(wr_addr[bw]), 64'd0);
    check("nom_addr1", 64'(wr_addr[bw+1]), 64'd1);
    check("nom_data0", wr_data[bw], W0);
    check("nom_data1", wr_data[bw+1], W1);
    check("nom_wlat",  64'(wr_cyc[bw] - acpt_cyc[ba]), 64'd1);
    check("nom_b2b",   64'(wr_cyc[bw+1] - wr_cyc[bw]), 64'd1);
    check("nom_nacc",  64'(n_acc - bacc), 64'd1);
    check("nom_acclat", 64'(acc_at - acpt_cyc[ba+1]), 64'd2);
    check("nom_busy",  64'(busy), 64'd1);
    check("nom_loaded", 64'(loaded_count), 64'd2);
    finish_run();
    check("nom_idle", 64'(busy), 64'd0);

    // Backpressure: valid 1,0,1,0,1,1.
    start(CW'(4));
    bw = n_wr; ba = n_acpt; bacc = n_acc;
    pattern = 6'b110101;
    for (int i = 0; i < 6; i++) begin
      host_valid = pattern[i];
      host_data  = 64'hA000 + 64'(i);
      tick();
    end
    host_valid = 1'b0;
    repeat (4) tick();
    check("bp_nwr", 64'(n_wr - bw), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_addr%0d", k), 64'(wr_addr[bw+k]), 64'(k));
      check($sformatf("bp_wlat%0d", k), 64'(wr_cyc[bw+k] - acpt_cyc[ba+k]), 64'd1);
    end
    check("bp_gap0", 64'(wr_cyc[bw+1] - wr_cyc[bw]), 64'd2);
    check("bp_gap1", 64'(wr_cyc[bw+2] - wr_cyc[bw+1]), 64'd2);
    check("bp_gap2", 64'(wr_cyc[bw+3] - wr_cyc[bw+2]), 64'd1);
    check("bp_data3", wr_data[bw+3], 64'hA005);
    check("bp_loaded", 64'(loaded_count), 64'd4);
    check("bp_nacc", 64'(n_acc - bacc), 64'd1);
    finish_run();

    // Illegal counts, then a legal single-word session.
    bw = n_wr; bacc = n_acc;
    start(CW'(0));
    check("ill0_err",  64'(err_count), 64'd1);
    check("ill0_busy", 64'(busy), 64'd0);
    start(CW'(1025));
    check("ill1_busy", 64'(busy), 64'd0);
    check("ill1_ready", 64'(host_ready), 64'd0);
    repeat (2) tick();
    check("ill_nwr",  64'(n_wr - bw), 64'd0);
    check("ill_nacc", 64'(n_acc - bacc), 64'd0);
    start(CW'(1));
    host_valid = 1'b1; host_data = 64'h1111; tick();
    host_valid = 1'b0;
    repeat (3) tick();
    check("one_nwr",  64'(n_wr - bw), 64'd1);
    check("one_data", wr_data[bw], 64'h1111);
    check("one_nacc", 64'(n_acc - bacc), 64'd1);
    check("one_err_sticky", 64'(err_count), 64'd1);
    finish_run();

    // Abort together with the third accept of an 8-word session.
    start(CW'(8));
    bw = n_wr; bacc = n_acc;
    host_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      host_data = 64'hB000 + 64'(i);
      abort     = (i == 2);
      tick();
    end
    host_valid = 1'b0; abort = 1'b0;
    check("ab_busy",  64'(busy), 64'd0);
    check("ab_ready", 64'(host_ready), 64'd0);
    repeat (4) tick();
    check("ab_nwr",   64'(n_wr - bw), 64'd3);
    check("ab_addr2", 64'(wr_addr[bw+2]), 64'd2);
    check("ab_data2", wr_data[bw+2], 64'hB002);
    check("ab_loaded", 64'(loaded_count), 64'd3);
    check("ab_nacc",  64'(n_acc - bacc), 64'd0);

    // host_start while in RUN.
    start(CW'(1));
    host_valid = 1'b1; host_data = 64'h2222; tick();
    host_valid = 1'b0;
    repeat (3) tick();
    bw = n_wr;
    check("run_errb_pre", 64'(err_busy), 64'd0);
    start(CW'(5));
    check("run_errb", 64'(err_busy), 64'd1);
    check("run_busy", 64'(busy), 64'd1);
    repeat (2) tick();
    check("run_nwr", 64'(n_wr - bw), 64'd0);
    finish_run();
    check("run_idle", 64'(busy), 64'd0);

    // Asynchronous reset after 5 of 10 words, with a write pending.
    start(CW'(10));
    host_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      host_data = 64'hC000 + 64'(i);
      tick();
    end
    host_data = 64'hC005;
    check("mr_we_pre", 64'(load_instr_enable), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mr_we",     64'(load_instr_enable), 64'd0);
    check("mr_addr",   64'(load_instr_addr), 64'd0);
    check("mr_data",   instr_data, 64'd0);
    check("mr_busy",   64'(busy), 64'd0);
    check("mr_ready",  64'(host_ready), 64'd0);
    check("mr_loaded", 64'(loaded_count), 64'd0);
    check("mr_errs",   64'({err_count, err_busy}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    host_valid = 1'b0;
    tick();
    check("mr_post_busy",  64'(busy), 64'd0);
    check("mr_post_ready", 64'(host_ready), 64'd0);
    check("mr_post_we",    64'(load_instr_enable), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Host-side writer for the accelerator instruction memory. The memory's reader is the CLP instruction fetch inside top.
- Accepts a burst of 64-bit instruction words over a valid/ready stream and writes them to consecutive addresses from 0.
- After the last word has been written, pulses acc_enable for exactly one cycle.
- Holds busy until top reports completion, so the memory cannot be overwritten mid-run.

Parameters:
- INSTR_W, 64, instruction word width.
- ADDR_W, 10, instruction memory address width.
- DEPTH, 1024, instruction memory depth; must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- host_start  in  1  request a load session; sampled only in IDLE.
- host_count  in  ADDR_W+1  number of words in the session; legal range 1..DEPTH.
- host_valid  in  1  host word valid.
- host_data  in  INSTR_W  host instruction word.
- host_ready  out  1  loader accepts a word this cycle.
- abort  in  1  abandon the current load.
- acc_done  in  1  single-cycle pulse from top when the instruction program has finished.
- load_instr_enable  out  1  memory write strobe.
- load_instr_addr  out  ADDR_W  memory write address.
- instr_data  out  INSTR_W  memory write data.
- acc_enable  out  1  one-cycle start pulse to top.
- busy  out  1  high in every state except IDLE.
- loaded_count  out  ADDR_W+1  words written in the most recent session.
- err_count  out  1  sticky: host_start seen with an illegal host_count.
- err_busy  out  1  sticky: host_start seen while not in IDLE.

Behaviour:
- Reset: state IDLE. All outputs 0, including the address and data registers, loaded_count and both error flags. The error flags clear only on rst.
- FSM states are IDLE, LOAD, LAUNCH and RUN.
- IDLE:
  - host_ready=0.
  - host_start with 1 ≤ host_count ≤ DEPTH: latch the count, clear the word counter and loaded_count, go to LOAD.
  - host_start with host_count=0 or host_count>DEPTH: set err_count, stay in IDLE.
- LOAD:
  - host_ready=1, combinational from state only; it does not depend on host_valid.
  - A word is accepted on a rising edge where host_valid & host_ready.
  - Write latency is 1 cycle: after accept edge N, load_instr_enable=1 during cycle N+1, with load_instr_addr = word index and instr_data = the accepted word.
  - The memory captures the word on edge N+1.
  - Back-to-back accepts give a write every cycle.
  - loaded_count increments on each accept.
  - The last accept (index = count-1) moves the FSM to LAUNCH, so host_ready is 0 on the following cycle.
- LAUNCH:
  - Lasts exactly 1 cycle; during it the final write strobe is active.
  - acc_enable=1 in the next cycle only (registered); the FSM enters RUN in that same cycle.
  - Net timing: last accept at edge N, last write during cycle N+1, acc_enable during cycle N+2.
- RUN:
  - busy=1, host_ready=0.
  - acc_done returns the FSM to IDLE on the next edge.
  - acc_done in any other state is ignored.
- abort:
  - In LOAD: go to IDLE at the next edge. A word accepted on that same edge is still written.
  - loaded_count keeps the number of words written; acc_enable is never pulsed.
  - In IDLE, LAUNCH and RUN, abort is ignored; the start pulse cannot be revoked.
- Simultaneous host_valid and abort in LOAD: the word is accepted and written, then the FSM goes to IDLE.
- host_start in LOAD, LAUNCH or RUN: set err_busy; the current session is unaffected.
- Address wrap: not possible, because count ≤ DEPTH is checked at start.
- load_instr_enable is 0 whenever no write is pending. The address and data registers hold their last values.
- Reset asserted mid-session: immediate return to IDLE, all outputs 0. A pending write is dropped with no strobe.

Decomposition:
- Shared package (tproc_pkg) holds:
  - INSTR_W, ADDR_W and DEPTH defaults;
  - the state encoding typedef for IDLE, LAUNCH, LOAD and RUN.
- One natural sub-module, instr_wr_stage: the 1-cycle write register holding strobe, address and data.
- The FSM and counters stay in instr_loader.

Test Plan:
- Nominal load: host_start with count=2, then words 64'h0003_1000_0001_5758 and 64'h0003_1000_0001_5759 on consecutive cycles.
  -> Writes go to addr 0 then 1 on consecutive cycles.
  -> acc_enable is high for exactly 1 cycle, 2 cycles after the second accept.
  -> busy stays 1 until acc_done, then returns to 0.
- Backpressure gaps: count=4 with host_valid toggling 1,0,1,0,1,1.
  -> Writes go to addr 0..3 with gaps mirroring the input.
  -> loaded_count=4; acc_enable pulses once.
- Illegal count: host_start with count=0, then count=1025.
  -> err_count=1; state stays IDLE; no write and no acc_enable.
  -> A following count=1 session still completes.
- Abort: count=8, abort asserted together with the 3rd accept.
  -> Writes go to addr 0..2; FSM returns to IDLE; loaded_count=3; acc_enable is never asserted.
- Start while running: host_start during RUN.
  -> err_busy=1; no new writes; acc_done returns the FSM to IDLE normally.
- Reset mid-load: rst asserted asynchronously after 5 of 10 words.
  -> All outputs 0 immediately; after release, state is IDLE and host_ready=0.
